// File: rtl/regfile_step_ctrl.sv
// Step-pulse sequencer for the lab register file: loads switch data, dumps registers to the display, zero-fills on request.
// Latency: a load/dump occupies the cycle after its step; a clear occupies 2^AW cycles after its clr pulse.
// Backpressure: none; step/clr pulses arriving while busy are dropped, never queued.
module regfile_step_ctrl #(
    parameter int AW = 3,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          clr,
    input  logic          mode,
    input  logic [DW-1:0] sw_data,
    input  logic [DW-1:0] rf_rdata,
    output logic          rf_we,
    output logic [AW-1:0] rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic [AW-1:0] rf_raddr,
    output logic [DW-1:0] disp_data,
    output logic [AW-1:0] disp_addr,
    output logic          busy,
    output logic          wrap
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_CLEAR = 2'd3;

    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] disp_data_q, disp_data_d;
    logic [AW-1:0] disp_addr_q, disp_addr_d;
    logic          busy_q;
    logic          wrap_q, wrap_d;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        disp_data_d = disp_data_q;
        disp_addr_d = disp_addr_q;
        wrap_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // clr wins over a coincident step, which is simply lost
                if (clr) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end else if (step) begin
                    if (!mode) begin
                        data_d  = sw_data;
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
                end
            end
            S_WRITE: begin
                ptr_d   = ptr_q + PTR_ONE;
                wrap_d  = &ptr_q;
                state_d = S_IDLE;
            end
            S_READ: begin
                disp_data_d = rf_rdata;
                disp_addr_d = ptr_q;
                ptr_d       = ptr_q + PTR_ONE;
                wrap_d      = &ptr_q;
                state_d     = S_IDLE;
            end
            S_CLEAR: begin
                ptr_d = ptr_q + PTR_ONE;
                if (&ptr_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            data_q      <= '0;
            disp_data_q <= '0;
            disp_addr_q <= '0;
            busy_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            disp_data_q <= disp_data_d;
            disp_addr_q <= disp_addr_d;
            busy_q      <= (state_d != S_IDLE);
            wrap_q      <= wrap_d;
        end
    end

    // Write port is decoded straight from state so the write lands in the WRITE/CLEAR cycle itself
    assign rf_we     = (state_q == S_WRITE) || (state_q == S_CLEAR);
    assign rf_waddr  = ptr_q;
    assign rf_wdata  = (state_q == S_CLEAR) ? '0 : data_q;
    assign rf_raddr  = ptr_q;
    assign disp_data = disp_data_q;
    assign disp_addr = disp_addr_q;
    assign busy      = busy_q;
    assign wrap      = wrap_q;

endmodule
